// File: rtl/pid_loop_sequencer_pkg.sv
// Shared types, defaults and helpers for the flight-loop sequencer.
package pid_loop_sequencer_pkg;

  localparam int LOOP_PERIOD_US_DEFAULT   = 2500;
  localparam int STAGE_TIMEOUT_US_DEFAULT = 200;

  typedef enum logic [6:0] {
    ST_IDLE      = 7'b000_0001,
    ST_WAIT_TICK = 7'b000_0010,
    ST_AC_RUN    = 7'b000_0100,
    ST_RC_RUN    = 7'b000_1000,
    ST_MM_RUN    = 7'b001_0000,
    ST_DONE      = 7'b010_0000,
    ST_FAULT     = 7'b100_0000
  } seq_state_e;

  typedef enum logic [1:0] {
    FAULT_NONE  = 2'd0,
    FAULT_ANGLE = 2'd1,
    FAULT_RATE  = 2'd2,
    FAULT_MIXER = 2'd3
  } fault_code_e;

  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/pid_loop_sequencer_tick_gen.sv
// Loop tick generator: free-running period counter while enabled, held at 0 otherwise.
module pid_loop_sequencer_tick_gen #(
  parameter int PERIOD = 2500
) (
  input  logic us_clk,
  input  logic resetn,
  input  logic enable,
  output logic tick
);

  localparam int            CW   = $clog2(PERIOD);
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] count;

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn)              count <= '0;
    else if (!enable)         count <= '0;
    else if (count == LAST)   count <= '0;
    else                      count <= count + 1'b1;
  end

  assign tick = enable && (count == LAST);

endmodule

// File: rtl/pid_loop_sequencer.sv
// Fixed-rate flight-loop scheduler: angle -> rate -> mixer per tick, with
// stage timeouts, overrun/stale accounting and fault-gated motor enable.
module pid_loop_sequencer
  import pid_loop_sequencer_pkg::*;
#(
  parameter int LOOP_PERIOD_US   = LOOP_PERIOD_US_DEFAULT,
  parameter int STAGE_TIMEOUT_US = STAGE_TIMEOUT_US_DEFAULT
) (
  input  logic       us_clk,
  input  logic       resetn,
  input  logic       arm,
  input  logic       imu_data_valid,
  output logic       ac_start,
  input  logic       ac_complete,
  output logic       rc_start,
  input  logic       rc_complete,
  output logic       mm_start,
  input  logic       mm_complete,
  output logic       loop_done,
  output logic       motor_enable,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [7:0] overrun_count,
  output logic [7:0] stale_count
);

  localparam int            TW      = $clog2(STAGE_TIMEOUT_US + 1);
  localparam logic [TW-1:0] TIMEOUT = TW'(STAGE_TIMEOUT_US);

  seq_state_e    state_q, state_d;
  fault_code_e   code_q, code_d;
  logic [TW-1:0] timer_q;
  logic          tick, imu_fresh, fresh_now, consume, in_run, busy, timed_out;
  logic          ac_start_d, rc_start_d, mm_start_d, loop_done_d;

  pid_loop_sequencer_tick_gen #(.PERIOD(LOOP_PERIOD_US)) u_tick_gen (
    .us_clk (us_clk),
    .resetn (resetn),
    .enable (arm),
    .tick   (tick)
  );

  // A sample arriving in the tick cycle itself still counts as fresh.
  assign fresh_now = imu_fresh || imu_data_valid;
  assign in_run    = state_q inside {ST_AC_RUN, ST_RC_RUN, ST_MM_RUN};
  assign busy      = in_run || (state_q == ST_DONE);
  assign timed_out = (timer_q == TIMEOUT);

  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    ac_start_d  = 1'b0;
    rc_start_d  = 1'b0;
    mm_start_d  = 1'b0;
    loop_done_d = 1'b0;
    consume     = 1'b0;
    if (!arm) begin
      state_d = ST_IDLE;
      code_d  = FAULT_NONE;
    end else begin
      unique case (state_q)
        ST_IDLE:      state_d = ST_WAIT_TICK;
        ST_WAIT_TICK: if (tick && fresh_now) begin
          ac_start_d = 1'b1;
          consume    = 1'b1;
          state_d    = ST_AC_RUN;
        end
        ST_AC_RUN: if (ac_complete) begin
          rc_start_d = 1'b1;
          state_d    = ST_RC_RUN;
        end else if (timed_out) begin
          state_d = ST_FAULT;
          code_d  = FAULT_ANGLE;
        end
        ST_RC_RUN: if (rc_complete) begin
          mm_start_d = 1'b1;
          state_d    = ST_MM_RUN;
        end else if (timed_out) begin
          state_d = ST_FAULT;
          code_d  = FAULT_RATE;
        end
        ST_MM_RUN: if (mm_complete) begin
          state_d = ST_DONE;
        end else if (timed_out) begin
          state_d = ST_FAULT;
          code_d  = FAULT_MIXER;
        end
        ST_DONE: begin
          loop_done_d = 1'b1;
          state_d     = ST_WAIT_TICK;
        end
        ST_FAULT: state_d = ST_FAULT;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      code_q        <= FAULT_NONE;
      timer_q       <= '0;
      imu_fresh     <= 1'b0;
      ac_start      <= 1'b0;
      rc_start      <= 1'b0;
      mm_start      <= 1'b0;
      loop_done     <= 1'b0;
      fault         <= 1'b0;
      motor_enable  <= 1'b0;
      overrun_count <= '0;
      stale_count   <= '0;
    end else begin
      code_q       <= code_d;
      ac_start     <= ac_start_d;
      rc_start     <= rc_start_d;
      mm_start     <= mm_start_d;
      loop_done    <= loop_done_d;
      fault        <= (state_d == ST_FAULT);
      motor_enable <= arm && (state_d != ST_FAULT);

      if (ac_start_d || rc_start_d || mm_start_d) timer_q <= '0;
      else if (in_run && !timed_out)              timer_q <= timer_q + 1'b1;

      if (!arm || consume)     imu_fresh <= 1'b0;
      else if (imu_data_valid) imu_fresh <= 1'b1;

      if ((state_q == ST_WAIT_TICK) && tick && !fresh_now)
        stale_count <= sat_inc(stale_count);
      // Ticks landing on a busy loop are dropped rather than queued.
      if (busy && tick)
        overrun_count <= sat_inc(overrun_count);
    end
  end

  assign fault_code = code_q;

endmodule

// File: doc/pid_loop_sequencer.md
# pid_loop_sequencer

Fixed-rate scheduler for the flight control loop. On each loop tick it checks for a fresh IMU sample, then runs angle_controller, the body-rate PID stage and the motor mixer in order, using their start/complete handshakes. It sits between the IMU interface and the control datapath, watches each stage for timeouts and loop overruns, and gates motor enable on fault.

## Interface
Parameters:
- LOOP_PERIOD_US, 2500: loop period in us_clk cycles (400 Hz); legal range ≥ 16.
- STAGE_TIMEOUT_US, 200: maximum cycles from a stage start pulse to its complete.

Ports:
- us_clk  in  1  1 MHz system clock.
- resetn  in  1  reset, asynchronous, active-low.
- arm  in  1  level; flight armed.
- imu_data_valid  in  1  one-cycle pulse; new pitch/roll sample latched upstream.
- ac_start  out  1  one-cycle start pulse to angle_controller.
- ac_complete  in  1  angle_controller complete_signal.
- rc_start  out  1  one-cycle start pulse to the rate controller.
- rc_complete  in  1  rate controller complete.
- mm_start  out  1  one-cycle start pulse to the motor mixer.
- mm_complete  in  1  motor mixer complete.
- loop_done  out  1  one-cycle pulse; full loop finished.
- motor_enable  out  1  high when armed and not faulted.
- fault  out  1  sticky; a stage timed out.
- fault_code  out  2  0 = none, 1 = angle stage, 2 = rate stage, 3 = mixer stage.
- overrun_count  out  8  saturating count of ticks dropped because the loop was busy.
- stale_count  out  8  saturating count of ticks skipped because there was no fresh IMU sample.

## Operation
- States: IDLE, WAIT_TICK, AC_RUN, RC_RUN, MM_RUN, DONE, FAULT.
- IDLE: entered while arm = 0. Period counter held at 0, imu_fresh cleared, all outputs low.
- arm rises: go to WAIT_TICK. Counters are not cleared by arm; only reset clears them.
- Tick: period counter counts 0..LOOP_PERIOD_US-1 while armed. Tick is asserted when the count equals LOOP_PERIOD_US-1.
- imu_fresh: set by imu_data_valid. Cleared in the cycle ac_start is issued.
- WAIT_TICK, tick with imu_fresh = 1: pulse ac_start, go to AC_RUN.
- WAIT_TICK, tick with imu_fresh = 0: increment stale_count, stay in WAIT_TICK.
- AC_RUN: on ac_complete, pulse rc_start and go to RC_RUN.
- RC_RUN: on rc_complete, pulse mm_start and go to MM_RUN.
- MM_RUN: on mm_complete, go to DONE.
- DONE: pulse loop_done for one cycle, return to WAIT_TICK.
- Stage timer: reloaded to 0 with every start pulse. It increments in each *_RUN state.
- Timeout: when the stage timer reaches STAGE_TIMEOUT_US, go to FAULT. Set fault, set fault_code to the current stage, deassert motor_enable.
- FAULT: held until arm = 0, then go to IDLE. Leaving FAULT clears fault and fault_code.
- Tick in any *_RUN or DONE state: the tick is dropped, not queued, and overrun_count increments.
- Both counters saturate at 255.
- motor_enable = arm && !fault, registered.

## Timing
- Reset values: every output 0, state IDLE, all counters 0.
- ac_start is asserted the cycle after the tick cycle.
- rc_start is asserted the cycle after ac_complete is sampled high; mm_start likewise after rc_complete.
- loop_done is asserted 2 cycles after mm_complete is sampled high.
- Completes are treated as levels sampled only in the matching *_RUN state. A complete arriving in any other state is ignored.
- Start pulses are exactly one cycle wide. angle_controller latches its start internally.
- Complete and timeout in the same cycle: complete wins.
- Tick and imu_data_valid in the same cycle: the sample counts as fresh.
- arm falls mid-loop: next cycle go to IDLE. No further start pulses; motor_enable low; no loop_done.
- resetn asserted mid-loop: all outputs drop immediately (asynchronous reset).
- Best-case loop with 4-cycle stages: tick to loop_done ≈ 16 cycles, well under LOOP_PERIOD_US.

## Structure
- common_defines.v: state one-hot localparams, FAULT_* codes, TRUE/FALSE.
- pid_parameters.v: LOOP_PERIOD_US and STAGE_TIMEOUT_US defaults.
- Sub-module loop_tick_gen: period counter with enable (arm) and one-cycle tick output.
- Counters and the FSM live in pid_loop_sequencer.

## Test plan
- Reset, arm = 1, imu_data_valid every 2500 cycles, stages completing in 4 cycles -> ac_start → rc_start → mm_start → loop_done each period; counts stay 0; motor_enable = 1.
- No imu_data_valid before the tick -> no ac_start; stale_count = 1; next tick with a fresh sample runs normally.
- rc_complete never asserted -> after 200 cycles in RC_RUN: fault = 1, fault_code = 2, motor_enable = 0. Drop arm -> IDLE, fault = 0.
- Mixer stalls for 3000 cycles (timeout raised to 4000) -> one tick dropped, overrun_count = 1, loop completes afterwards.
- arm dropped during AC_RUN -> IDLE next cycle; ac_complete later is ignored; no rc_start or loop_done.
- 300 consecutive stale ticks -> stale_count saturates at 255.
